pcie_ts_rx: RTL

- Receive-side parser for Gen1/Gen2 training sequence ordered sets (TS1/TS2).
- Takes one 8b/10b-decoded symbol per cycle from the lane deframer, plus a K-flag. Locks onto COM, captures link/lane/N_FTS/rate/control fields and checks the 10 TS-ID symbols.
- Counts consecutive identical TSs for the LTSSM: Polling.Active needs 8 consecutive, Configuration needs 2.
- Sits between the per-lane symbol decoder and the LTSSM, mirroring the transmit-side TS generator.

---
 rtl/pcie_phy_pkg.sv | 42 ++++
 rtl/pcie_ts_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: ordered-set symbol encodings, TS layout and
// the receive-side TS parser state/compare types.
package pcie_phy_pkg;

  localparam logic [7:0] PCIE_SYM_COM = 8'hBC;
  localparam logic [7:0] PCIE_SYM_PAD = 8'hF7;
  localparam logic [7:0] PCIE_TS1_ID  = 8'h4A;
  localparam logic [7:0] PCIE_TS2_ID  = 8'h45;

  localparam int unsigned TS_LEN    = 16;
  localparam int unsigned TS_ID_LEN = 10;

  // Symbol 0 (COM) occupies the most significant byte.
  typedef struct packed {
    logic [7:0]                com;
    logic [7:0]                link_num;
    logic [7:0]                lane_num;
    logic [7:0]                n_fts;
    logic [7:0]                rate_id;
    logic [7:0]                train_ctrl;
    logic [TS_ID_LEN-1:0][7:0] ts_id;
  } pcie_tsos_t;

  typedef struct packed {
    logic [7:0] link;
    logic [7:0] lane;
    logic [7:0] nfts;
    logic [7:0] rate;
    logic [7:0] ctrl;
  } pcie_ts_fields_t;

  typedef enum logic [2:0] {
    StHunt,
    StLink,
    StLane,
    StNfts,
    StRate,
    StCtrl,
    StId
  } pcie_ts_rx_state_e;

endpackage

// File: rtl/pcie_ts_rx.sv
// Receive-side TS1/TS2 ordered-set parser: locks on COM, captures the TS fields,
// validates the ID symbols and counts consecutive identical good TSs.
module pcie_ts_rx
  import pcie_phy_pkg::*;
#(
  parameter int unsigned CONSEC_TARGET = 8,
  parameter int unsigned CNT_WIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            sym_i,
  input  logic                  sym_k_i,
  input  logic                  sym_valid_i,
  input  logic                  clear_i,
  output logic [TS_LEN*8-1:0]   ts_o,
  output logic                  ts_type_o,
  output logic                  ts_valid_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  consec_cnt_o,
  output logic                  consec_hit_o
);

  localparam logic [3:0]           LastIdx = 4'(TS_ID_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
  localparam logic [CNT_WIDTH-1:0] Target  = CNT_WIDTH'(CONSEC_TARGET);

  pcie_ts_rx_state_e    state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  pcie_ts_fields_t      fld_q, fld_d;
  logic                 typ_q, typ_d;
  pcie_tsos_t           ts_q, ts_d;
  logic                 ts_type_q, ts_type_d;
  logic                 ts_valid_q, ts_valid_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  pcie_ts_fields_t      prev_fld_q, prev_fld_d;
  logic                 prev_typ_q, prev_typ_d;
  logic                 prev_vld_q, prev_vld_d;

  logic       is_com, is_pad, is_d, bad, done;
  logic [7:0] id_exp;

  assign is_com = sym_k_i && (sym_i == PCIE_SYM_COM);
  assign is_pad = sym_k_i && (sym_i == PCIE_SYM_PAD);
  assign is_d   = !sym_k_i;
  assign id_exp = typ_q ? PCIE_TS2_ID : PCIE_TS1_ID;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fld_d      = fld_q;
    typ_d      = typ_q;
    ts_d       = ts_q;
    ts_type_d  = ts_type_q;
    ts_valid_d = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    prev_fld_d = prev_fld_q;
    prev_typ_d = prev_typ_q;
    prev_vld_d = prev_vld_q;
    bad        = 1'b0;
    done       = 1'b0;

    if (sym_valid_i) begin
      unique case (state_q)
        StHunt: if (is_com) state_d = StLink;
        StLink: begin
          if (is_d || is_pad) begin
            fld_d.link = sym_i;
            state_d    = StLane;
          end else bad = 1'b1;
        end
        StLane: begin
          if (is_d || is_pad) begin
            fld_d.lane = sym_i;
            state_d    = StNfts;
          end else bad = 1'b1;
        end
        StNfts: begin
          if (is_d) begin
            fld_d.nfts = sym_i;
            state_d    = StRate;
          end else bad = 1'b1;
        end
        StRate: begin
          if (is_d) begin
            fld_d.rate = sym_i;
            state_d    = StCtrl;
          end else bad = 1'b1;
        end
        StCtrl: begin
          if (is_d) begin
            fld_d.ctrl = sym_i;
            idx_d      = '0;
            state_d    = StId;
          end else bad = 1'b1;
        end
        StId: begin
          if (idx_q == '0) begin
            // First ID symbol decides TS1 vs TS2 for the rest of the set.
            if (is_d && sym_i == PCIE_TS1_ID)      typ_d = 1'b0;
            else if (is_d && sym_i == PCIE_TS2_ID) typ_d = 1'b1;
            else                                   bad   = 1'b1;
            idx_d = 4'd1;
          end else if (is_d && sym_i == id_exp) begin
            if (idx_q == LastIdx) begin
              done    = 1'b1;
              state_d = StHunt;
            end else idx_d = idx_q + 4'd1;
          end else bad = 1'b1;
        end
        default: state_d = StHunt;
      endcase
    end

    if (bad) begin
      err_d   = 1'b1;
      cnt_d   = '0;
      state_d = is_com ? StLink : StHunt;
    end

    if (done) begin
      ts_d.com        = PCIE_SYM_COM;
      ts_d.link_num   = fld_q.link;
      ts_d.lane_num   = fld_q.lane;
      ts_d.n_fts      = fld_q.nfts;
      ts_d.rate_id    = fld_q.rate;
      ts_d.train_ctrl = fld_q.ctrl;
      ts_d.ts_id      = {TS_ID_LEN{id_exp}};
      ts_type_d       = typ_q;
      ts_valid_d      = 1'b1;
      // A coincident clear makes this TS the first of a new run.
      if (prev_vld_q && !clear_i && prev_typ_q == typ_q && prev_fld_q == fld_q) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CNT_WIDTH'(1);
      end
      prev_fld_d = fld_q;
      prev_typ_d = typ_q;
      prev_vld_d = 1'b1;
    end else if (clear_i) begin
      cnt_d      = '0;
      prev_vld_d = 1'b0;
    end

    hit_d = (cnt_d >= Target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      idx_q      <= '0;
      fld_q      <= '0;
      typ_q      <= 1'b0;
      ts_q       <= '0;
      ts_type_q  <= 1'b0;
      ts_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      prev_fld_q <= '0;
      prev_typ_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fld_q      <= fld_d;
      typ_q      <= typ_d;
      ts_q       <= ts_d;
      ts_type_q  <= ts_type_d;
      ts_valid_q <= ts_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      hit_q      <= hit_d;
      prev_fld_q <= prev_fld_d;
      prev_typ_q <= prev_typ_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign ts_o         = ts_q;
  assign ts_type_o    = ts_type_q;
  assign ts_valid_o   = ts_valid_q;
  assign err_o        = err_q;
  assign consec_cnt_o = cnt_q;
  assign consec_hit_o = hit_q;

endmodule
